// File: rtl/r30_reverse_stepper.sv
// Rule-30 reverse stepper: walks a final row backwards D steps using a per-step rightmost-cell hint.
// Optional center-column capture is built only when R30_REVERSE_COLUMN_EN is defined.
module r30_reverse_stepper #(
  parameter int N = 128,
  parameter int D = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_state,
  input  logic [D-1:0] in_hint,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_seed,
  output logic         out_consistent,
  output logic [7:0]   out_first_bad,
  output logic [D-1:0] out_column
);
  localparam int SW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  row;
  logic [D-1:0]  hint;
  logic [SW-1:0] step;
  logic          consistent;
  logic [7:0]    first_bad;

  // Ripple from the right edge: the hint pins prev[N-1], each next cell then fixes its left neighbour.
  // Cell 0 has no left neighbour to absorb the residue, so it becomes the consistency check.
  function automatic logic [N:0] reverse_step(input logic [N-1:0] nxt, input logic h);
    logic [N:0] p;
    p      = '0;
    p[N-1] = h;
    for (int i = N - 1; i >= 1; i--)
      p[i-1] = nxt[i] ^ (p[i] | p[i+1]);
    return {nxt[0] != (p[0] | p[1]), p[N-1:0]};
  endfunction

  logic [N:0]   rev;
  logic [N-1:0] prev;
  logic         bad;

  assign rev  = reverse_step(row, hint[step]);
  assign prev = rev[N-1:0];
  assign bad  = rev[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      row        <= '0;
      hint       <= '0;
      step       <= '0;
      consistent <= 1'b0;
      first_bad  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          row        <= in_state;
          hint       <= in_hint;
          step       <= SW'(D - 1);
          consistent <= 1'b1;
          first_bad  <= '0;
          in_ready   <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          row <= prev;
          if (bad) begin
            consistent <= 1'b0;
            if (consistent) first_bad <= 8'(step);
          end
          if (step == '0) state <= DONE;
          else            step  <= step - 1'b1;
        end
        DONE: begin
          // out_valid rises on the edge after DONE entry, then holds until consumed
          if (!out_valid) out_valid <= 1'b1;
          else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_seed       = row;
  assign out_consistent = consistent;
  assign out_first_bad  = first_bad;

`ifdef R30_REVERSE_COLUMN_EN
  logic [D-1:0] column;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     column       <= '0;
    else if (state == IDLE && in_valid && in_ready) column       <= '0;
    else if (state == RUN)                          column[step] <= prev[N/2];
  end

  assign out_column = column;
`else
  assign out_column = '0;
`endif

endmodule

// File: tb/tb_r30_reverse_stepper.sv
// Self-checking bench for r30_reverse_stepper: three sizes (128x256, 8x8, 8x1) against a
// forward-simulation / brute-force-inverse reference model.
module tb_r30_reverse_stepper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default size
  logic         b_valid = 1'b0, b_oready = 1'b0;
  logic         b_ready, b_ovalid, b_cons;
  logic [127:0] b_state = '0, b_seed;
  logic [255:0] b_hint = '0, b_col;
  logic [7:0]   b_fb;
  // N=8, D=8
  logic       e_valid = 1'b0, e_oready = 1'b0;
  logic       e_ready, e_ovalid, e_cons;
  logic [7:0] e_state = '0, e_hint = '0, e_seed, e_col, e_fb;
  // N=8, D=1
  logic       o_valid = 1'b0, o_oready = 1'b0;
  logic       o_ready, o_ovalid, o_cons;
  logic [7:0] o_state = '0, o_seed, o_fb;
  logic [0:0] o_hint = '0, o_col;

  r30_reverse_stepper #(.N(128), .D(256)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_state(b_state),
    .in_hint(b_hint), .out_valid(b_ovalid), .out_ready(b_oready), .out_seed(b_seed),
    .out_consistent(b_cons), .out_first_bad(b_fb), .out_column(b_col));

  r30_reverse_stepper #(.N(8), .D(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_valid), .in_ready(e_ready), .in_state(e_state),
    .in_hint(e_hint), .out_valid(e_ovalid), .out_ready(e_oready), .out_seed(e_seed),
    .out_consistent(e_cons), .out_first_bad(e_fb), .out_column(e_col));

  r30_reverse_stepper #(.N(8), .D(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(o_valid), .in_ready(o_ready), .in_state(o_state),
    .in_hint(o_hint), .out_valid(o_ovalid), .out_ready(o_oready), .out_seed(o_seed),
    .out_consistent(o_cons), .out_first_bad(o_fb), .out_column(o_col));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forward rule with zero cells outside the row.
  function automatic logic [127:0] fwd128(input logic [127:0] p);
    logic [127:0] n;
    logic l, r;
    for (int i = 0; i < 128; i++) begin
      l = (i > 0)   ? p[i-1] : 1'b0;
      r = (i < 127) ? p[i+1] : 1'b0;
      n[i] = l ^ (p[i] | r);
    end
    return n;
  endfunction

  function automatic logic [7:0] fwd8(input logic [7:0] p);
    logic [7:0] n;
    logic l, r;
    for (int i = 0; i < 8; i++) begin
      l = (i > 0) ? p[i-1] : 1'b0;
      r = (i < 7) ? p[i+1] : 1'b0;
      n[i] = l ^ (p[i] | r);
    end
    return n;
  endfunction

  // Inverse by exhaustive search: the unique predecessor with the given rightmost cell that
  // reproduces cells 1..7; the step is bad if it then misses cell 0.
  task automatic rev8(input logic [7:0] nxt, input logic h, output logic [7:0] prv, output logic bad);
    logic [7:0] c, f;
    prv = 'x;
    bad = 1'b1;
    for (int k = 0; k < 256; k++) begin
      c = 8'(k);
      f = fwd8(c);
      if (c[7] == h && f[7:1] == nxt[7:1]) begin
        prv = c;
        bad = (f[0] != nxt[0]);
      end
    end
  endtask

  task automatic run_small(input bit one, input logic [7:0] row, input logic [7:0] hint, input string tag);
    int d, lat;
    logic [7:0] cur, p, col, fb;
    logic cons, bad;
    d = one ? 1 : 8;
    cur = row; cons = 1'b1; fb = '0; col = '0;
    for (int s = d - 1; s >= 0; s--) begin
      rev8(cur, hint[s], p, bad);
      if (bad) begin
        if (cons) fb = 8'(s);
        cons = 1'b0;
      end
      col[s] = p[4];
      cur = p;
    end
    chk({tag, "_ready"}, one ? o_ready : e_ready, 1'b1);
    @(negedge clk);
    if (one) begin o_valid = 1'b1; o_state = row; o_hint = hint[0]; end
    else     begin e_valid = 1'b1; e_state = row; e_hint = hint; end
    @(posedge clk); #1;
    o_valid = 1'b0; e_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!(one ? o_ovalid : e_ovalid) && lat < 400);
    chk({tag, "_latency"}, lat, d + 1);
    chk({tag, "_seed"}, one ? o_seed : e_seed, cur);
    chk({tag, "_consistent"}, one ? o_cons : e_cons, cons);
    chk({tag, "_first_bad"}, one ? o_fb : e_fb, fb);
`ifdef R30_REVERSE_COLUMN_EN
    chk({tag, "_column"}, one ? 8'(o_col) : e_col, one ? 8'(col[0]) : col);
`else
    chk({tag, "_column"}, one ? 8'(o_col) : e_col, 8'h0);
`endif
    @(negedge clk);
    if (one) o_oready = 1'b1; else e_oready = 1'b1;
    @(posedge clk); #1;
    o_oready = 1'b0; e_oready = 1'b0;
    chk({tag, "_consumed"}, one ? o_ovalid : e_ovalid, 1'b0);
  endtask

  logic [127:0] st [0:256];

  task automatic load_big(input logic [127:0] seed, output logic [255:0] col);
    st[0] = seed;
    for (int s = 0; s < 256; s++) begin
      st[s+1]   = fwd128(st[s]);
      b_hint[s] = st[s][127];
      col[s]    = st[s][64];
    end
    b_state = st[256];
  endtask

  task automatic run_big(input logic [127:0] seed, input int hold, input string tag);
    int lat;
    logic [255:0] col;
    @(negedge clk);
    load_big(seed, col);
    chk({tag, "_ready"}, b_ready, 1'b1);
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!b_ovalid && lat < 2000);
    chk({tag, "_latency"}, lat, 257);
    chk({tag, "_seed"}, b_seed, seed);
    chk({tag, "_consistent"}, b_cons, 1'b1);
    chk({tag, "_first_bad"}, b_fb, 8'h0);
`ifdef R30_REVERSE_COLUMN_EN
    chk({tag, "_column"}, b_col, col);
`else
    chk({tag, "_column"}, b_col, 256'h0);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      b_valid = 1'($urandom_range(0, 1));
      b_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, b_ovalid, 1'b1);
      chk({tag, "_hold_ready"}, b_ready, 1'b0);
      chk({tag, "_hold_seed"}, b_seed, seed);
      chk({tag, "_hold_cons"}, b_cons, 1'b1);
    end
    b_valid = 1'b0;
    @(negedge clk); b_oready = 1'b1;
    @(posedge clk); #1; b_oready = 1'b0;
    chk({tag, "_consumed"}, b_ovalid, 1'b0);
    chk({tag, "_ready_again"}, b_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] s8, h8, r8;
    logic [255:0] dummy_col;

    #12;
    chk("rst_big_ready", b_ready, 1'b1);
    chk("rst_big_valid", b_ovalid, 1'b0);
    chk("rst_big_seed", b_seed, 128'h0);
    chk("rst_big_cons", b_cons, 1'b0);
    chk("rst_d8_valid", e_ovalid, 1'b0);
    chk("rst_d8_fb", e_fb, 8'h0);
    @(negedge clk) rst_n = 1'b1;

    run_small(1'b1, 8'h38, 8'h00, "d1_38");
    run_small(1'b1, 8'h01, 8'h00, "d1_01");

    // 8x8 round trips: clean, then with hint bit 5 flipped
    for (int t = 0; t < 3; t++) begin
      s8 = 8'($urandom);
      r8 = s8;
      for (int s = 0; s < 8; s++) begin
        h8[s] = r8[7];
        r8 = fwd8(r8);
      end
      run_small(1'b0, r8, h8, "d8_trip");
      chk("d8_trip_origin", e_seed, s8);
      run_small(1'b0, r8, h8 ^ 8'h20, "d8_flip5");
    end
    for (int t = 0; t < 6; t++)
      run_small(1'b0, 8'($urandom), 8'($urandom), "d8_rand");

    run_big(128'h1 << 64, 0, "big_center");
    run_big({$urandom, $urandom, $urandom, $urandom}, 20, "big_bp");

    // reset mid-RUN must clear outputs without waiting for a clock edge
    @(negedge clk);
    load_big({$urandom, $urandom, $urandom, $urandom}, dummy_col);
    b_valid = 1'b1;
    @(posedge clk); #1; b_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", b_ovalid, 1'b0);
    chk("midrst_ready", b_ready, 1'b1);
    chk("midrst_seed", b_seed, 128'h0);
    chk("midrst_cons", b_cons, 1'b0);
    chk("midrst_fb", b_fb, 8'h0);
    chk("midrst_col", b_col, 256'h0);
    @(negedge clk) rst_n = 1'b1;
    run_big(128'h1 << 64, 0, "big_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
